// File: rtl/scan_chain_ctrl_if.sv
// Bundle of the test-access and scan-chain signals of one scan_chain_ctrl.
// The master side is the test-access logic plus the chain's scan-out; the
// slave side is the controller itself.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 START;
    logic [CHAIN_LEN-1:0] PAT;
    logic [CHAIN_LEN-1:0] EXP;
    logic [CHAIN_LEN-1:0] MSK;
    logic                 SO;
    logic                 TE;
    logic                 TI;
    logic                 BUSY;
    logic                 DONE;
    logic [CHAIN_LEN-1:0] UNLOAD;
    logic                 MISMATCH;

    modport master (
        output START, PAT, EXP, MSK, SO,
        input  TE, TI, BUSY, DONE, UNLOAD, MISMATCH
    );

    modport slave (
        input  START, PAT, EXP, MSK, SO,
        output TE, TI, BUSY, DONE, UNLOAD, MISMATCH
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-chain load/capture/unload controller for a single mux-scan chain.
// One START shifts PAT in MSB-first, pulses one functional capture, then
// shifts the response out into UNLOAD and compares it against EXP under MSK.
// TE and TI are driven straight from flops; BUSY decodes the state register.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic               CP,
    input  logic               RST,
    scan_chain_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t               stateQ,    stateD;
    logic [CNT_W-1:0]     cntQ,      cntD;
    logic [CHAIN_LEN-1:0] loadQ,     loadD;
    logic [CHAIN_LEN-1:0] expQ,      expD;
    logic [CHAIN_LEN-1:0] mskQ,      mskD;
    logic [CHAIN_LEN-1:0] unloadQ,   unloadD;
    logic                 teQ,       teD;
    logic                 tiQ,       tiD;
    logic                 doneQ,     doneD;
    logic                 mismatchQ, mismatchD;

    // Next-state and next-output logic; TE/TI are computed one cycle ahead so they leave flops.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        loadD     = loadQ;
        expD      = expQ;
        mskD      = mskQ;
        unloadD   = unloadQ;
        teD       = teQ;
        tiD       = tiQ;
        doneD     = 1'b0;
        mismatchD = mismatchQ;

        case (stateQ)
            IDLE: begin
                teD = 1'b0;
                tiD = 1'b0;
                if (bus.START) begin
                    tiD    = bus.PAT[CHAIN_LEN-1];
                    teD    = 1'b1;
                    loadD  = {bus.PAT[CHAIN_LEN-2:0], 1'b0};
                    expD   = bus.EXP;
                    mskD   = bus.MSK;
                    cntD   = '0;
                    stateD = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                if (cntQ == LAST_CNT) begin
                    teD    = 1'b0;
                    tiD    = 1'b0;
                    cntD   = '0;
                    stateD = CAPTURE;
                end else begin
                    tiD   = loadQ[CHAIN_LEN-1];
                    loadD = {loadQ[CHAIN_LEN-2:0], 1'b0};
                    cntD  = cntQ + ONE_CNT;
                end
            end
            CAPTURE: begin
                teD    = 1'b1;
                tiD    = 1'b0;
                cntD   = '0;
                stateD = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                tiD     = 1'b0;
                unloadD = {unloadQ[CHAIN_LEN-2:0], bus.SO};
                if (cntQ == LAST_CNT) begin
                    teD       = 1'b0;
                    doneD     = 1'b1;
                    mismatchD = |((unloadD ^ expQ) & mskQ);
                    cntD      = '0;
                    stateD    = IDLE;
                end else begin
                    cntD = cntQ + ONE_CNT;
                end
            end
            default: begin
                teD    = 1'b0;
                tiD    = 1'b0;
                cntD   = '0;
                stateD = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that also wipes the latched operands.
    always_ff @(posedge CP) begin
        if (RST) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            loadQ     <= '0;
            expQ      <= '0;
            mskQ      <= '0;
            unloadQ   <= '0;
            teQ       <= 1'b0;
            tiQ       <= 1'b0;
            doneQ     <= 1'b0;
            mismatchQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            loadQ     <= loadD;
            expQ      <= expD;
            mskQ      <= mskD;
            unloadQ   <= unloadD;
            teQ       <= teD;
            tiQ       <= tiD;
            doneQ     <= doneD;
            mismatchQ <= mismatchD;
        end
    end

    assign bus.TE       = teQ;
    assign bus.TI       = tiQ;
    assign bus.BUSY     = (stateQ != IDLE);
    assign bus.DONE     = doneQ;
    assign bus.UNLOAD   = unloadQ;
    assign bus.MISMATCH = mismatchQ;

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Scan-chain load/capture/unload controller: the driving end of a mux-scan chain built from scan flip-flops (TE selects TI over D at the rising edge of CP). One START runs a full test sequence on a single chain of CHAIN_LEN cells:

- shift a pattern in;
- pulse one functional capture;
- shift the captured response out and compare it against an expected, masked value.

It sits between the test-access logic and one chain: its TE and TI outputs drive every cell's TE and the first cell's TI, and the last cell's Q returns on SO.

## Interface

Parameters:
- CHAIN_LEN, default 8: number of scan cells in the chain; minimum 2.
- CNT_W, default $clog2(CHAIN_LEN)+1: width of the shift counter.

Ports:
- CP  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begins a sequence; sampled only in IDLE.
- PAT  in  CHAIN_LEN  load pattern; bit j ends up in chain cell j; sampled on the accepted START.
- EXP  in  CHAIN_LEN  expected captured value; sampled on the accepted START.
- MSK  in  CHAIN_LEN  compare mask, 1 = compare bit; sampled on the accepted START.
- SO  in  1  scan-out, Q of chain cell CHAIN_LEN-1.
- TE  out  1  scan enable to all cells; registered.
- TI  out  1  scan data to chain cell 0; registered.
- BUSY  out  1  high in SHIFT_IN, CAPTURE and SHIFT_OUT.
- DONE  out  1  one-cycle pulse when UNLOAD and MISMATCH become valid.
- UNLOAD  out  CHAIN_LEN  captured chain contents; bit j = cell j.
- MISMATCH  out  1  |((UNLOAD ^ EXP) & MSK) for the last sequence.

## Operation

States and transitions:
- IDLE: waits for START.
- SHIFT_IN: CHAIN_LEN cycles.
- CAPTURE: 1 cycle.
- SHIFT_OUT: CHAIN_LEN cycles.
- From SHIFT_OUT, back to IDLE.

Behaviour per state:
- IDLE:
  - TE=0, TI=0.
  - On START: latch PAT into the load shift register, latch EXP and MSK, clear the counter, go to SHIFT_IN.
- SHIFT_IN:
  - TE=1; TI presents PAT bits MSB-first, so TI = PAT[CHAIN_LEN-1-k] during shift k.
  - After CHAIN_LEN shifts, cell j holds PAT[j].
  - Data arriving on SO during SHIFT_IN is discarded.
- CAPTURE:
  - TE=0, TI=0; the chain loads its functional D inputs at the end of this cycle.
- SHIFT_OUT:
  - TE=1, TI=0.
  - At each edge: UNLOAD <= {UNLOAD[CHAIN_LEN-2:0], SO}. The first sample is cell CHAIN_LEN-1, so after CHAIN_LEN samples UNLOAD[j] = captured cell j.
  - On the last sample edge: register MISMATCH from the final UNLOAD value, pulse DONE, go to IDLE.

Boundary conditions:
- START while BUSY=1 is ignored; it has no effect on the latched PAT, EXP or MSK.
- START in the DONE cycle (state is IDLE) is accepted.
- UNLOAD and MISMATCH hold their values until the final sample edge of the next sequence. UNLOAD bits shift during SHIFT_OUT of the next run, so they are valid only while BUSY=0.
- RST in any state:
  - returns to IDLE;
  - TE=0, TI=0, BUSY=0, DONE=0, UNLOAD=0, MISMATCH=0;
  - clears the counter and the latched PAT, EXP and MSK.
- RST wins over a simultaneous START.

## Timing

- Let edge 0 be the edge that accepts START.
- Edges 1..CHAIN_LEN: the chain shifts PAT in. TE=1 from after edge 0 until edge CHAIN_LEN.
- Edge CHAIN_LEN+1: functional capture. TE=0 in the cycle before it.
- Edges CHAIN_LEN+2..2*CHAIN_LEN+1: the controller samples SO while the chain shifts.
- After edge 2*CHAIN_LEN+1: DONE=1 for exactly one cycle, BUSY=0, UNLOAD and MISMATCH valid.
- Total latency from START to DONE: 2*CHAIN_LEN+1 cycles.
- TE and TI come straight from flops; there are no combinational paths from any input to any output.
- Counter width covers CHAIN_LEN without wrap. The counter resets to 0 at each state entry.

## Test plan

The bench chain model is CHAIN_LEN=8 mux-scan flops with D driven by a constant functional value F.

- Reset: assert RST for 2 cycles with START=1 → TE=0, TI=0, BUSY=0, DONE=0, UNLOAD=8'h00, MISMATCH=0; no sequence starts.
- Load check: PAT=8'hA5 → after edge 8, chain cells equal 8'hA5; the TI sequence is 1,0,1,0,0,1,0,1.
- Full pass: PAT=8'hA5, F=8'h3C, EXP=8'h3C, MSK=8'hFF → DONE after edge 17, UNLOAD=8'h3C, MISMATCH=0.
- Masked fail: F=8'h3D, EXP=8'h3C:
  - with MSK=8'hFF → MISMATCH=1;
  - rerun with MSK=8'hFE → MISMATCH=0.
- Back-to-back and ignored START:
  - pulse START during SHIFT_IN → no effect, DONE still after edge 17;
  - START in the DONE cycle → the second run starts immediately, DONE 17 cycles later.
- Reset mid-operation: RST during CAPTURE → next cycle state IDLE, TE=0, BUSY=0, no DONE; a subsequent START completes normally.
